adam_axil_mem_bridge: RTL and testbench

Multi-channel AXI-Lite slave to single-port SRAM bridge: the next generation of the memory-port glue at the ADAM top level. Each of `NO_CHANNELS` independent channels accepts AXI-Lite reads and writes, drives one synchronous 1-cycle-latency SRAM macro, and supports the ADAM pause req/ack protocol and a per-channel soft reset. Signals are flattened per channel, so the block drops straight into the synthesis top between the `mem_axil` ports and technology SRAMs.

---
 rtl/adam_axil_mem_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_adam_axil_mem_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_axil_mem_bridge.sv
// Multi-channel AXI-Lite slave to single-port SRAM bridge with per-channel pause and soft reset.
// Define ADAM_MEM_BRIDGE_ERR_EN to answer addresses beyond the SRAM depth with SLVERR.
module adam_axil_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NO_CHANNELS    = 4,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int STRB_WIDTH     = DATA_WIDTH/8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NO_CHANNELS-1:0]              srst,
    input  logic [NO_CHANNELS-1:0]              pause_req,
    output logic [NO_CHANNELS-1:0]              pause_ack,
    input  logic [ADDR_WIDTH*NO_CHANNELS-1:0]   axil_aw_addr,
    input  logic [3*NO_CHANNELS-1:0]            axil_aw_prot,
    input  logic [NO_CHANNELS-1:0]              axil_aw_valid,
    output logic [NO_CHANNELS-1:0]              axil_aw_ready,
    input  logic [DATA_WIDTH*NO_CHANNELS-1:0]   axil_w_data,
    input  logic [STRB_WIDTH*NO_CHANNELS-1:0]   axil_w_strb,
    input  logic [NO_CHANNELS-1:0]              axil_w_valid,
    output logic [NO_CHANNELS-1:0]              axil_w_ready,
    output logic [2*NO_CHANNELS-1:0]            axil_b_resp,
    output logic [NO_CHANNELS-1:0]              axil_b_valid,
    input  logic [NO_CHANNELS-1:0]              axil_b_ready,
    input  logic [ADDR_WIDTH*NO_CHANNELS-1:0]   axil_ar_addr,
    input  logic [3*NO_CHANNELS-1:0]            axil_ar_prot,
    input  logic [NO_CHANNELS-1:0]              axil_ar_valid,
    output logic [NO_CHANNELS-1:0]              axil_ar_ready,
    output logic [DATA_WIDTH*NO_CHANNELS-1:0]   axil_r_data,
    output logic [2*NO_CHANNELS-1:0]            axil_r_resp,
    output logic [NO_CHANNELS-1:0]              axil_r_valid,
    input  logic [NO_CHANNELS-1:0]              axil_r_ready,
    output logic [NO_CHANNELS-1:0]              mem_req,
    output logic [NO_CHANNELS-1:0]              mem_we,
    output logic [MEM_ADDR_WIDTH*NO_CHANNELS-1:0] mem_addr,
    output logic [DATA_WIDTH*NO_CHANNELS-1:0]   mem_wdata,
    output logic [STRB_WIDTH*NO_CHANNELS-1:0]   mem_be,
    input  logic [DATA_WIDTH*NO_CHANNELS-1:0]   mem_rdata
);

    localparam int LSB = $clog2(STRB_WIDTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_MEM  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_MEM  = 3'd3;
    localparam logic [2:0] RD_CAP  = 3'd4;
    localparam logic [2:0] RD_RESP = 3'd5;
    localparam logic [2:0] PAUSED  = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic unused_prot;
    assign unused_prot = ^{axil_aw_prot, axil_ar_prot};

    for (genvar i = 0; i < NO_CHANNELS; i++) begin : g_ch
        logic [ADDR_WIDTH-1:0]     aw_addr, ar_addr;
        logic [DATA_WIDTH-1:0]     w_data, rdata_in;
        logic [STRB_WIDTH-1:0]     w_strb;
        logic                      wr_req, aw_err, ar_err, arb, unused_addr;

        logic [2:0]                state_q, state_d;
        logic                      prio_q, prio_d, err_q, err_d;
        logic                      awr_q, awr_d, arr_q, arr_d;
        logic                      bvalid_q, bvalid_d, rvalid_q, rvalid_d;
        logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
        logic [DATA_WIDTH-1:0]     rdata_q, rdata_d, mwdata_q, mwdata_d;
        logic                      mreq_q, mreq_d, mwe_q, mwe_d, pack_q, pack_d;
        logic [MEM_ADDR_WIDTH-1:0] maddr_q, maddr_d;
        logic [STRB_WIDTH-1:0]     mbe_q, mbe_d;

        assign aw_addr     = axil_aw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign ar_addr     = axil_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data      = axil_w_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb      = axil_w_strb[i*STRB_WIDTH +: STRB_WIDTH];
        assign rdata_in    = mem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign wr_req      = axil_aw_valid[i] && axil_w_valid[i];
        assign unused_addr = ^{aw_addr, ar_addr};

`ifdef ADAM_MEM_BRIDGE_ERR_EN
        assign aw_err = |aw_addr[ADDR_WIDTH-1:LSB+MEM_ADDR_WIDTH];
        assign ar_err = |ar_addr[ADDR_WIDTH-1:LSB+MEM_ADDR_WIDTH];
`else
        assign aw_err = 1'b0;
        assign ar_err = 1'b0;
`endif

        // Readies are registered, so whenever the FSM lands in IDLE the request
        // arbitration for the following cycle is decided on the same edge (arb).
        always_comb begin
            state_d  = state_q;
            prio_d   = prio_q;
            err_d    = err_q;
            awr_d    = 1'b0;
            arr_d    = 1'b0;
            bvalid_d = bvalid_q;
            bresp_d  = bresp_q;
            rvalid_d = rvalid_q;
            rresp_d  = rresp_q;
            rdata_d  = rdata_q;
            mreq_d   = 1'b0;
            mwe_d    = 1'b0;
            maddr_d  = maddr_q;
            mwdata_d = mwdata_q;
            mbe_d    = mbe_q;
            pack_d   = pack_q;
            arb      = 1'b0;

            case (state_q)
                IDLE: begin
                    if (awr_q && wr_req) begin
                        state_d  = WR_MEM;
                        maddr_d  = aw_addr[LSB +: MEM_ADDR_WIDTH];
                        mwdata_d = w_data;
                        mbe_d    = w_strb;
                        mreq_d   = !aw_err;
                        mwe_d    = 1'b1;
                        err_d    = aw_err;
                        prio_d   = !prio_q;
                    end else if (arr_q && axil_ar_valid[i]) begin
                        state_d  = RD_MEM;
                        maddr_d  = ar_addr[LSB +: MEM_ADDR_WIDTH];
                        mreq_d   = !ar_err;
                        err_d    = ar_err;
                        prio_d   = !prio_q;
                    end else if (!awr_q && !arr_q && pause_req[i]) begin
                        state_d  = PAUSED;
                        pack_d   = 1'b1;
                    end else begin
                        arb      = 1'b1;
                    end
                end
                WR_MEM: begin
                    state_d  = WR_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
                end
                WR_RESP: begin
                    if (axil_b_ready[i]) begin
                        state_d  = IDLE;
                        bvalid_d = 1'b0;
                        arb      = !pause_req[i];
                    end
                end
                RD_MEM: state_d = RD_CAP;
                RD_CAP: begin
                    state_d  = RD_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = err_q ? '0 : rdata_in;
                    rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
                end
                RD_RESP: begin
                    if (axil_r_ready[i]) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b0;
                        arb      = !pause_req[i];
                    end
                end
                PAUSED: begin
                    if (!pause_req[i]) begin
                        state_d = IDLE;
                        pack_d  = 1'b0;
                        arb     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (arb) begin
                if (wr_req && (!prio_q || !axil_ar_valid[i])) awr_d = 1'b1;
                else if (axil_ar_valid[i])                   arr_d = 1'b1;
            end

            // Soft reset wins over everything, including pause and in-flight responses.
            if (srst[i]) begin
                state_d  = IDLE;
                prio_d   = 1'b0;
                err_d    = 1'b0;
                awr_d    = 1'b0;
                arr_d    = 1'b0;
                bvalid_d = 1'b0;
                bresp_d  = RESP_OKAY;
                rvalid_d = 1'b0;
                rresp_d  = RESP_OKAY;
                rdata_d  = '0;
                mreq_d   = 1'b0;
                mwe_d    = 1'b0;
                pack_d   = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= IDLE;
                prio_q   <= 1'b0;
                err_q    <= 1'b0;
                awr_q    <= 1'b0;
                arr_q    <= 1'b0;
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
                rvalid_q <= 1'b0;
                rresp_q  <= RESP_OKAY;
                rdata_q  <= '0;
                mreq_q   <= 1'b0;
                mwe_q    <= 1'b0;
                maddr_q  <= '0;
                mwdata_q <= '0;
                mbe_q    <= '0;
                pack_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                prio_q   <= prio_d;
                err_q    <= err_d;
                awr_q    <= awr_d;
                arr_q    <= arr_d;
                bvalid_q <= bvalid_d;
                bresp_q  <= bresp_d;
                rvalid_q <= rvalid_d;
                rresp_q  <= rresp_d;
                rdata_q  <= rdata_d;
                mreq_q   <= mreq_d;
                mwe_q    <= mwe_d;
                maddr_q  <= maddr_d;
                mwdata_q <= mwdata_d;
                mbe_q    <= mbe_d;
                pack_q   <= pack_d;
            end
        end

        assign axil_aw_ready[i]                          = awr_q;
        assign axil_w_ready[i]                           = awr_q;
        assign axil_ar_ready[i]                          = arr_q;
        assign axil_b_valid[i]                           = bvalid_q;
        assign axil_b_resp[2*i +: 2]                     = bresp_q;
        assign axil_r_valid[i]                           = rvalid_q;
        assign axil_r_resp[2*i +: 2]                     = rresp_q;
        assign axil_r_data[i*DATA_WIDTH +: DATA_WIDTH]   = rdata_q;
        assign mem_req[i]                                = mreq_q;
        assign mem_we[i]                                 = mwe_q;
        assign mem_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = maddr_q;
        assign mem_wdata[i*DATA_WIDTH +: DATA_WIDTH]     = mwdata_q;
        assign mem_be[i*STRB_WIDTH +: STRB_WIDTH]        = mbe_q;
        assign pause_ack[i]                              = pack_q;
    end

endmodule

// File: tb/tb_adam_axil_mem_bridge.sv
// Directed bench for adam_axil_mem_bridge: a table of single transactions plus
// hand-written sequences for arbitration, pause, soft reset and async reset.
module tb_adam_axil_mem_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NC  = 4;
    localparam int MAW = 10;
    localparam int SW  = 4;

`ifdef ADAM_MEM_BRIDGE_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        int          id;
        int          ch;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [9:0]  expAddr;
        bit          expReq;
        logic [1:0]  expResp;
        logic [31:0] expRdata;
    } vecT;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   srst, pauseReq, pauseAck;
    logic [AW*NC-1:0] awAddr, arAddr;
    logic [3*NC-1:0] awProt, arProt;
    logic [NC-1:0]   awValid, awReady, wValid, wReady, bValid, bReady;
    logic [NC-1:0]   arValid, arReady, rValid, rReady, memReq, memWe;
    logic [DW*NC-1:0] wData, rData, memWdata, memRdata;
    logic [SW*NC-1:0] wStrb, memBe;
    logic [2*NC-1:0] bResp, rResp;
    logic [MAW*NC-1:0] memAddr;
    logic [DW-1:0]   sram [NC][2**MAW];

    int nCompared   = 0;
    int nMismatched = 0;
    vecT vecs[18];

    always #5 clk = ~clk;

    adam_axil_mem_bridge dut (
        .clk(clk), .rst(rst), .srst(srst),
        .pause_req(pauseReq), .pause_ack(pauseAck),
        .axil_aw_addr(awAddr), .axil_aw_prot(awProt), .axil_aw_valid(awValid), .axil_aw_ready(awReady),
        .axil_w_data(wData), .axil_w_strb(wStrb), .axil_w_valid(wValid), .axil_w_ready(wReady),
        .axil_b_resp(bResp), .axil_b_valid(bValid), .axil_b_ready(bReady),
        .axil_ar_addr(arAddr), .axil_ar_prot(arProt), .axil_ar_valid(arValid), .axil_ar_ready(arReady),
        .axil_r_data(rData), .axil_r_resp(rResp), .axil_r_valid(rValid), .axil_r_ready(rReady),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_be(memBe), .mem_rdata(memRdata)
    );

    // Behavioural SRAM per channel: byte-enabled writes, 1-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                memRdata[c*DW +: DW] <= '0;
                for (int a = 0; a < 2**MAW; a++) sram[c][a] <= '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (memReq[c] && memWe[c]) begin
                    for (int b = 0; b < SW; b++)
                        if (memBe[c*SW+b])
                            sram[c][memAddr[c*MAW +: MAW]][b*8 +: 8] <= memWdata[c*DW+b*8 +: 8];
                end else if (memReq[c]) begin
                    memRdata[c*DW +: DW] <= sram[c][memAddr[c*MAW +: MAW]];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge of the cycle in which the ready pulse is visible.
    task automatic waitReady(input int ch, input bit rd);
        int  n = 0;
        logic seen;
        @(negedge clk);
        seen = rd ? arReady[ch] : (awReady[ch] && wReady[ch]);
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = rd ? arReady[ch] : (awReady[ch] && wReady[ch]);
        end
        checkOutput(rd ? "ar_ready pulse" : "aw_ready+w_ready pulse", {31'd0, seen}, 32'd1);
    endtask

    task automatic applyStimulus(input vecT v);
        int c = v.ch;
        if (v.wr) begin
            awAddr[c*AW +: AW] = v.addr;
            wData[c*DW +: DW]  = v.wdata;
            wStrb[c*SW +: SW]  = v.strb;
            awValid[c] = 1'b1;
            wValid[c]  = 1'b1;
            waitReady(c, 1'b0);
            @(negedge clk);
            awValid[c] = 1'b0;
            wValid[c]  = 1'b0;
            checkOutput($sformatf("v%0d wr mem_req", v.id), {31'd0, memReq[c]}, {31'd0, v.expReq});
            if (v.expReq) begin
                checkOutput($sformatf("v%0d mem_we", v.id), {31'd0, memWe[c]}, 32'd1);
                checkOutput($sformatf("v%0d mem_addr", v.id), {22'd0, memAddr[c*MAW +: MAW]}, {22'd0, v.expAddr});
                checkOutput($sformatf("v%0d mem_be", v.id), {28'd0, memBe[c*SW +: SW]}, {28'd0, v.strb});
                checkOutput($sformatf("v%0d mem_wdata", v.id), memWdata[c*DW +: DW], v.wdata);
            end
            checkOutput($sformatf("v%0d b_valid at T+1", v.id), {31'd0, bValid[c]}, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("v%0d b_valid at T+2", v.id), {31'd0, bValid[c]}, 32'd1);
            checkOutput($sformatf("v%0d b_resp", v.id), {30'd0, bResp[2*c +: 2]}, {30'd0, v.expResp});
            @(negedge clk);
            checkOutput($sformatf("v%0d b_valid after handshake", v.id), {31'd0, bValid[c]}, 32'd0);
        end else begin
            arAddr[c*AW +: AW] = v.addr;
            arValid[c] = 1'b1;
            waitReady(c, 1'b1);
            @(negedge clk);
            arValid[c] = 1'b0;
            checkOutput($sformatf("v%0d rd mem_req", v.id), {31'd0, memReq[c]}, {31'd0, v.expReq});
            if (v.expReq) begin
                checkOutput($sformatf("v%0d mem_we", v.id), {31'd0, memWe[c]}, 32'd0);
                checkOutput($sformatf("v%0d mem_addr", v.id), {22'd0, memAddr[c*MAW +: MAW]}, {22'd0, v.expAddr});
            end
            @(negedge clk);
            checkOutput($sformatf("v%0d r_valid at T+2", v.id), {31'd0, rValid[c]}, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("v%0d r_valid at T+3", v.id), {31'd0, rValid[c]}, 32'd1);
            checkOutput($sformatf("v%0d r_data", v.id), rData[c*DW +: DW], v.expRdata);
            checkOutput($sformatf("v%0d r_resp", v.id), {30'd0, rResp[2*c +: 2]}, {30'd0, v.expResp});
            @(negedge clk);
            checkOutput($sformatf("v%0d r_valid after handshake", v.id), {31'd0, rValid[c]}, 32'd0);
        end
    endtask

    function automatic vecT mkVec(input int id, input int ch, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb, input logic [9:0] ea,
                                  input bit er, input logic [1:0] ers, input logic [31:0] erd);
        vecT v;
        v.id = id; v.ch = ch; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.expAddr = ea; v.expReq = er; v.expResp = ers; v.expRdata = erd;
        return v;
    endfunction

    initial begin
        logic [1:0] expWin [3];
        logic [1:0] win;
        int n;

        expWin = '{2'b01, 2'b10, 2'b01};

        //               id ch wr addr           wdata          strb  expAddr  req   resp            rdata
        vecs[0]  = mkVec( 0, 0, 1, 32'h10,       32'hDEADBEEF, 4'hF, 10'd4,   1'b1, 2'd0,           32'h0);
        vecs[1]  = mkVec( 1, 0, 0, 32'h10,       32'h0,        4'h0, 10'd4,   1'b1, 2'd0,           32'hDEADBEEF);
        vecs[2]  = mkVec( 2, 0, 1, 32'h13,       32'h11223344, 4'h3, 10'd4,   1'b1, 2'd0,           32'h0);
        vecs[3]  = mkVec( 3, 0, 0, 32'h12,       32'h0,        4'h0, 10'd4,   1'b1, 2'd0,           32'hDEAD3344);
        vecs[4]  = mkVec( 4, 0, 1, 32'h14,       32'hAAAA5555, 4'h0, 10'd5,   1'b1, 2'd0,           32'h0);
        vecs[5]  = mkVec( 5, 0, 0, 32'h14,       32'h0,        4'h0, 10'd5,   1'b1, 2'd0,           32'h0);
        vecs[6]  = mkVec( 6, 2, 1, 32'hFFC,      32'h0BADF00D, 4'hF, 10'h3FF, 1'b1, 2'd0,           32'h0);
        vecs[7]  = mkVec( 7, 2, 0, 32'hFFC,      32'h0,        4'h0, 10'h3FF, 1'b1, 2'd0,           32'h0BADF00D);
        vecs[8]  = mkVec( 8, 2, 0, 32'h10,       32'h0,        4'h0, 10'd4,   1'b1, 2'd0,           32'h0);
        vecs[9]  = mkVec( 9, 0, 0, 32'h0001_0000, 32'h0,       4'h0, 10'd0,   !ERR, ERR ? 2'd2 : 2'd0, 32'h0);
        vecs[10] = mkVec(10, 1, 1, 32'h1000,     32'h12345678, 4'hF, 10'd0,   !ERR, ERR ? 2'd2 : 2'd0, 32'h0);
        vecs[11] = mkVec(11, 1, 0, 32'h0,        32'h0,        4'h0, 10'd0,   1'b1, 2'd0,           ERR ? 32'h0 : 32'h12345678);
        vecs[12] = mkVec(12, 3, 1, 32'h8,        32'hCAFEBABE, 4'hF, 10'd2,   1'b1, 2'd0,           32'h0);
        vecs[13] = mkVec(13, 3, 0, 32'h8,        32'h0,        4'h0, 10'd2,   1'b1, 2'd0,           32'hCAFEBABE);
        vecs[14] = mkVec(14, 3, 1, 32'hA,        32'h00FF00FF, 4'hC, 10'd2,   1'b1, 2'd0,           32'h0);
        vecs[15] = mkVec(15, 3, 0, 32'h8,        32'h0,        4'h0, 10'd2,   1'b1, 2'd0,           32'h00FFBABE);
        vecs[16] = mkVec(16, 0, 1, 32'h40,       32'h5A5AA5A5, 4'hF, 10'd16,  1'b1, 2'd0,           32'h0);
        vecs[17] = mkVec(17, 0, 0, 32'h40,       32'h0,        4'h0, 10'd16,  1'b1, 2'd0,           32'h5A5AA5A5);

        rst = 1'b1; srst = '0; pauseReq = '0;
        awAddr = '0; arAddr = '0; awProt = '0; arProt = '0;
        awValid = '0; wValid = '0; arValid = '0; wData = '0; wStrb = '0;
        bReady = '1; rReady = '1;

        repeat (3) @(negedge clk);
        checkOutput("reset aw_ready", {28'd0, awReady}, 32'd0);
        checkOutput("reset ar_ready", {28'd0, arReady}, 32'd0);
        checkOutput("reset b_valid", {28'd0, bValid}, 32'd0);
        checkOutput("reset r_valid", {28'd0, rValid}, 32'd0);
        checkOutput("reset mem_req", {28'd0, memReq}, 32'd0);
        checkOutput("reset pause_ack", {28'd0, pauseAck}, 32'd0);
        checkOutput("reset r_data ch0", rData[31:0], 32'd0);
        checkOutput("reset mem_addr ch0-2", memAddr[31:0], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin on channel 1: both requests raised together three times.
        for (int r = 0; r < 3; r++) begin
            awAddr[AW +: AW] = 32'h20; arAddr[AW +: AW] = 32'h20;
            wData[DW +: DW] = r; wStrb[SW +: SW] = 4'hF;
            awValid[1] = 1'b1; wValid[1] = 1'b1; arValid[1] = 1'b1;
            n = 0;
            @(negedge clk);
            while (!awReady[1] && !arReady[1] && n < 20) begin
                @(negedge clk);
                n++;
            end
            win = {arReady[1], awReady[1]};
            checkOutput($sformatf("arb round %0d winner", r), {30'd0, win}, {30'd0, expWin[r]});
            @(negedge clk);
            awValid[1] = 1'b0; wValid[1] = 1'b0; arValid[1] = 1'b0;
            repeat (4) @(negedge clk);
        end

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        // Pause from plain IDLE acknowledges one cycle later.
        pauseReq[0] = 1'b1;
        @(negedge clk);
        checkOutput("idle pause_ack latency", {31'd0, pauseAck[0]}, 32'd1);
        pauseReq[0] = 1'b0;
        @(negedge clk);
        checkOutput("idle pause release", {31'd0, pauseAck[0]}, 32'd0);

        // Pause requested mid-read waits for the R handshake.
        rReady[2] = 1'b0;
        arAddr[2*AW +: AW] = 32'hFFC;
        arValid[2] = 1'b1;
        waitReady(2, 1'b1);
        @(negedge clk);
        arValid[2] = 1'b0;
        pauseReq[2] = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checkOutput("pause: r_valid held", {31'd0, rValid[2]}, 32'd1);
            checkOutput("pause: no ack before r handshake", {31'd0, pauseAck[2]}, 32'd0);
            @(negedge clk);
        end
        rReady[2] = 1'b1;
        @(negedge clk);
        checkOutput("pause: r_valid dropped", {31'd0, rValid[2]}, 32'd0);
        arValid[2] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("pause: pause_ack", {31'd0, pauseAck[2]}, 32'd1);
            checkOutput("pause: no readies", {30'd0, arReady[2], awReady[2]}, 32'd0);
            @(negedge clk);
        end
        arValid[2] = 1'b0;
        @(negedge clk);
        pauseReq[2] = 1'b0;
        @(negedge clk);
        checkOutput("pause: ack clears next cycle", {31'd0, pauseAck[2]}, 32'd0);

        // Soft reset on channel 3 during RD_RESP while channel 2 holds its own response.
        rReady[2] = 1'b0; rReady[3] = 1'b0;
        arAddr[2*AW +: AW] = 32'hFFC; arAddr[3*AW +: AW] = 32'h8;
        arValid[2] = 1'b1; arValid[3] = 1'b1;
        waitReady(3, 1'b1);
        checkOutput("srst: ch2 ar_ready alongside", {31'd0, arReady[2]}, 32'd1);
        @(negedge clk);
        arValid[2] = 1'b0; arValid[3] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("srst: ch3 r_valid before", {31'd0, rValid[3]}, 32'd1);
        srst[3] = 1'b1;
        @(negedge clk);
        srst[3] = 1'b0;
        checkOutput("srst: ch3 r_valid cleared", {31'd0, rValid[3]}, 32'd0);
        checkOutput("srst: ch3 r_data cleared", rData[3*DW +: DW], 32'd0);
        checkOutput("srst: ch2 r_valid kept", {31'd0, rValid[2]}, 32'd1);
        checkOutput("srst: ch2 r_data kept", rData[2*DW +: DW], 32'h0BADF00D);
        rReady[2] = 1'b1; rReady[3] = 1'b1;
        @(negedge clk);
        checkOutput("srst: ch2 handshake", {31'd0, rValid[2]}, 32'd0);
        applyStimulus(vecs[15]);

        // Asynchronous reset in the middle of a write.
        awAddr[AW-1:0] = 32'h40; wData[DW-1:0] = 32'h5A5AA5A5; wStrb[SW-1:0] = 4'hF;
        awValid[0] = 1'b1; wValid[0] = 1'b1;
        waitReady(0, 1'b0);
        @(negedge clk);
        awValid[0] = 1'b0; wValid[0] = 1'b0;
        checkOutput("rst: mem_req before", {31'd0, memReq[0]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst: mem_req dropped", {28'd0, memReq}, 32'd0);
        checkOutput("rst: mem_we cleared", {28'd0, memWe}, 32'd0);
        checkOutput("rst: mem_addr cleared", {22'd0, memAddr[MAW-1:0]}, 32'd0);
        checkOutput("rst: mem_be cleared", {16'd0, memBe}, 32'd0);
        checkOutput("rst: b_valid", {28'd0, bValid}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst: b_valid stays low", {31'd0, bValid[0]}, 32'd0);
        applyStimulus(vecs[16]);
        applyStimulus(vecs[17]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
